dac_chain_tx: RTL and testbench
===============================

Name: dac_chain_tx

Overview:
Transmit-side counterpart of the ADC capture chain. Accepts baseband/passband DAC samples on an AXI-Stream slave at aclk (100 MHz), buffers them in a small FIFO, and plays them out to a parallel DAC at a programmable rate (aclk/clk_div). It also generates the DAC sample clock (ClockToDAC). Sits downstream of the TX upconverter/interpolator and drives the DAC pins directly.

Parameters:
DATA_W, 16, DAC sample width in bits.
FIFO_DEPTH, 16, sample FIFO depth; must be a power of 2.
PRIME_LEVEL, 8, FIFO occupancy required before playout starts or restarts; must satisfy 1 <= PRIME_LEVEL <= FIFO_DEPTH.
DIV_W, 16, width of the clk_div input.

Ports:
aclk  in  1  system clock, 100 MHz.
aresetn  in  1  asynchronous active-low reset.
DAC_control  in  4  [0] enable playout; [1] clear underflow counter; [3:2] reserved, ignored.
clk_div  in  DIV_W  aclk cycles per DAC sample; values below 2 are treated as 2.
S_AXIS_tdata  in  DATA_W  sample, two's complement.
S_AXIS_tvalid  in  1  sample valid.
S_AXIS_tready  out  1  FIFO can accept a sample.
DACdata  out  DATA_W  registered DAC sample.
ClockToDAC  out  1  DAC sample clock; DAC latches on the rising edge.
status  out  32  {4'b0, empty, full, state[1:0], level[7:0] zero-extended, underflow_cnt[15:0]}; empty is bit 27, full is bit 26.

Behaviour:
Clock and reset:
- Single clock domain; all state is on aclk.
- Reset is asynchronous assert, synchronous release.
- Reset values: DACdata = ZERO_CODE, ClockToDAC = 0, S_AXIS_tready = 0, FIFO empty, underflow_cnt = 0, state = IDLE, divider count = 0.
- ZERO_CODE is 0 in the base build (see Optional Feature).

FIFO:
- A push occurs when S_AXIS_tvalid && S_AXIS_tready.
- S_AXIS_tready is registered and equals !full; it goes to 1 on the first clock after reset release.
- Simultaneous push and pop leaves the level unchanged and is legal when full, since the pop frees a slot the same cycle.
- A pop never occurs when the FIFO is empty.
- The FIFO accepts pushes in every state, including IDLE (preload).
- Contents are retained across enable toggles and cleared only by reset.

Divider:
- div_q latches max(clk_div, 2) on the IDLE->PRIME transition. Changes to clk_div while running are ignored.
- cnt runs 0..div_q-1 in PRIME and RUN. It is held at 0 in IDLE.
- strobe = (cnt == div_q-1).
- ClockToDAC is registered: 0 while cnt < floor(div_q/2), otherwise 1.
- DACdata updates on the same edge at which cnt wraps to 0, i.e. coincident with the ClockToDAC falling edge. This gives floor(div_q/2) aclk cycles of setup before the rising edge.

State machine:
- IDLE (0): ClockToDAC = 0, DACdata = ZERO_CODE. Goes to PRIME when DAC_control[0] = 1.
- PRIME (1): ClockToDAC toggles and DACdata = ZERO_CODE. On a strobe with level >= PRIME_LEVEL: pop the head into DACdata and go to RUN.
- RUN (2): on each strobe, pop the head into DACdata if the FIFO is non-empty. If it is empty: DACdata = ZERO_CODE, underflow_cnt += 1 (saturating at 0xFFFF), go to PRIME.
- From any state, DAC_control[0] = 0 returns the block to IDLE on the next clock. The divider resets, ClockToDAC = 0, DACdata = ZERO_CODE, and no pop occurs that cycle.
- State encoding 3 is unreachable; if entered, the block recovers to IDLE.

Underflow counter clear:
- DAC_control[1] = 1 clears underflow_cnt to 0.
- If a clear and an underflow event occur in the same cycle, the clear wins.

Latency:
- A sample is output at the first strobe after it reaches the FIFO head in RUN, and is held for exactly div_q aclk cycles.

Optional Feature:
Macro DAC_OFFSET_BINARY_EN.
- Defined: DACdata is offset binary: the MSB of each popped sample is inverted, and ZERO_CODE = 1 << (DATA_W-1) (0x8000), including the reset value.
- Not defined: DACdata is two's complement pass-through and ZERO_CODE = 0.
- No other behaviour changes.

Test Plan:
1. Reset check: hold aresetn low for 5 cycles, release.
   - While low: DACdata = 0, ClockToDAC = 0, S_AXIS_tready = 0, status = 0x0800_0000.
   - One cycle after release: S_AXIS_tready = 1.
2. Normal playout: clk_div = 10, enable, stream ramp 0..99 with tvalid held high.
   - ClockToDAC period is 10 aclk (5 low / 5 high); DACdata = 0,1,2,...,99, each value held 10 cycles and changing at the ClockToDAC falling edge.
   - Playout begins only after 8 samples are queued; status[15:0] = 0 at the end of the stream.
3. Underflow: enable with clk_div = 4, push 8 samples, then stop.
   - Output 8 values, then DACdata = 0, status[15:0] = 1, status[25:24] = 1.
   - Push 8 more: playout resumes. Pulse DAC_control[1]: status[15:0] = 0.
4. Backpressure: enable = 0, offer 20 samples.
   - Exactly 16 accepted; S_AXIS_tready = 0; status[23:16] = 16, status bit 26 = 1; ClockToDAC stays 0.
5. Divider floor: clk_div = 1, enable.
   - ClockToDAC period is 2 aclk; one sample per 2 cycles.
   - Changing clk_div to 6 mid-RUN has no effect until disable and re-enable.
6. Reset mid-operation: assert aresetn during RUN.
   - All outputs take reset values immediately (asynchronously); after release, FIFO level = 0 and state = IDLE.
   - With DAC_OFFSET_BINARY_EN defined: reset DACdata = 0x8000; samples 0x0000 and 0xFFFF play out as 0x8000 and 0x7FFF.

Source files
------------

// File: rtl/dac_chain_tx.sv
// rtl/dac_chain_tx.sv - AXI-Stream fed DAC playout with sample FIFO, rate divider and DAC clock.
// Optional macro DAC_OFFSET_BINARY_EN selects offset-binary DAC coding (zero code 0x8000).
module dac_chain_tx #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int DIV_W       = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        DAC_control,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] S_AXIS_tdata,
  input  logic              S_AXIS_tvalid,
  output logic              S_AXIS_tready,
  output logic [DATA_W-1:0] DACdata,
  output logic              ClockToDAC,
  output logic [31:0]       status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME_LEVEL);

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] ZERO_CODE = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] ZERO_CODE = '0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic                clk_q, clk_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                tready_q, tready_d;
  logic [15:0]         ucnt_q, ucnt_d;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic [LW-1:0]       level, level_d;
  logic                empty, full, push, pop, strobe, enable, underflow;
  logic [DIV_W-1:0]    div_eff;
  logic [DATA_W-1:0]   head, head_coded;
  logic [7:0]          level8;
  logic                unused_ctrl;

  assign unused_ctrl = ^DAC_control[3:2];
  assign enable      = DAC_control[0];
  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (level == '0);
  assign full        = (level == FULL_LVL);
  assign push        = S_AXIS_tvalid && tready_q;
  assign strobe      = (cnt_q == div_q - DIV_W'(1));
  assign div_eff     = (clk_div < DIV_W'(2)) ? DIV_W'(2) : clk_div;
  assign head        = mem[rd_ptr_q[AW-1:0]];

`ifdef DAC_OFFSET_BINARY_EN
  assign head_coded = {~head[DATA_W-1], head[DATA_W-2:0]};
`else
  assign head_coded = head;
`endif

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    pop       = 1'b0;
    underflow = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      data_d  = ZERO_CODE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PRIME;
          div_d   = div_eff;
          cnt_d   = '0;
          data_d  = ZERO_CODE;
        end
        ST_PRIME: begin
          cnt_d  = strobe ? '0 : cnt_q + DIV_W'(1);
          data_d = ZERO_CODE;
          if (strobe && level >= PRIME_LVL) begin
            pop     = 1'b1;
            data_d  = head_coded;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_d = strobe ? '0 : cnt_q + DIV_W'(1);
          if (strobe) begin
            if (!empty) begin
              pop    = 1'b1;
              data_d = head_coded;
            end else begin
              data_d    = ZERO_CODE;
              underflow = 1'b1;
              state_d   = ST_PRIME;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          data_d  = ZERO_CODE;
        end
      endcase
    end
  end

  // DAC clock is low for the first half of each sample period, so data changes on its falling edge.
  always_comb begin
    clk_d = 1'b0;
    if (state_d == ST_PRIME || state_d == ST_RUN) begin
      clk_d = (cnt_d >= (div_d >> 1));
    end
  end

  always_comb begin
    ucnt_d = ucnt_q;
    if (DAC_control[1]) begin
      ucnt_d = '0;
    end else if (underflow && ucnt_q != 16'hFFFF) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_comb begin
    level_d = level;
    if (push && !pop) begin
      level_d = level + LW'(1);
    end else if (pop && !push) begin
      level_d = level - LW'(1);
    end
    tready_d = (level_d != FULL_LVL);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      div_q    <= DIV_W'(2);
      cnt_q    <= '0;
      clk_q    <= 1'b0;
      data_q   <= ZERO_CODE;
      tready_q <= 1'b0;
      ucnt_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      clk_q    <= clk_d;
      data_q   <= data_d;
      tready_q <= tready_d;
      ucnt_q   <= ucnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= S_AXIS_tdata;
  end

  assign level8        = 8'(level);
  assign S_AXIS_tready = tready_q;
  assign DACdata       = data_q;
  assign ClockToDAC    = clk_q;
  assign status        = {4'b0, empty, full, state_q, level8, ucnt_q};

endmodule

// File: tb/tb_dac_chain_tx.sv
// tb/tb_dac_chain_tx.sv - scoreboard bench for dac_chain_tx playout, underflow, backpressure and reset.
module tb_dac_chain_tx;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] ZERO = 16'h8000;
`else
  localparam logic [15:0] ZERO = 16'h0000;
`endif

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  DAC_control;
  logic [15:0] clk_div;
  logic [15:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [15:0] DACdata;
  logic        ClockToDAC;
  logic [31:0] status;

  dac_chain_tx dut (
    .aclk(aclk), .aresetn(aresetn), .DAC_control(DAC_control), .clk_div(clk_div),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .DACdata(DACdata), .ClockToDAC(ClockToDAC), .status(status)
  );

  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [15:0] exp_q[$];
  int          exp_div  = 10;
  logic        mon_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] coded(input logic [15:0] d);
`ifdef DAC_OFFSET_BINARY_EN
    return {~d[15], d[14:0]};
`else
    return d;
`endif
  endfunction

  task automatic send(input logic [15:0] d);
    int guard = 0;
    S_AXIS_tdata  = d;
    S_AXIS_tvalid = 1'b1;
    while (!S_AXIS_tready && guard < 2000) begin
      @(negedge aclk);
      guard++;
    end
    if (!S_AXIS_tready) begin
      check_eq("send_timeout", 0, 1);
    end else begin
      exp_q.push_back(coded(d));
      @(negedge aclk);
    end
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic wait_drained(input string tag, input int budget);
    int guard = 0;
    while (exp_q.size() != 0 && guard < budget) begin
      @(negedge aclk);
      guard++;
    end
    if (exp_q.size() != 0) check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    int guard = 0;
    while (status[25:24] != st && guard < budget) begin
      @(negedge aclk);
      guard++;
    end
    if (status[25:24] != st) check_eq(tag, status[25:24], st);
  endtask

  // Playout monitor: each DAC clock falling edge in RUN must present the next queued sample.
  int          cyc = 0, last_pop = -1, hi_cnt = 0;
  logic        prev_clk = 1'b0;
  logic [1:0]  prev_st = 2'd0;
  logic [7:0]  prev_lvl = 8'd0;
  logic [15:0] last_val = 16'h0;

  always @(posedge aclk) begin
    logic fell;
    logic [15:0] e;
    #1;
    if (mon_en) begin
      cyc++;
      fell = prev_clk && !ClockToDAC;
      if (prev_st == 2'd1 && status[25:24] == 2'd2) check_eq("prime_level", {31'b0, prev_lvl >= 8'd8}, 1);
      if (status[25:24] == 2'd2) begin
        if (fell) begin
          if (exp_q.size() == 0) begin
            check_eq("pop_extra", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("dacdata", DACdata, e);
            last_val = e;
          end
          if (last_pop >= 0) begin
            check_eq("period", cyc - last_pop, exp_div);
            check_eq("high_time", hi_cnt, exp_div - exp_div / 2);
          end
          last_pop = cyc;
          hi_cnt   = 0;
        end else begin
          check_eq("hold", DACdata, last_val);
          if (ClockToDAC) hi_cnt++;
        end
      end else begin
        check_eq("zero_out", DACdata, ZERO);
        last_pop = -1;
        hi_cnt   = 0;
      end
      prev_clk = ClockToDAC;
      prev_st  = status[25:24];
      prev_lvl = status[23:16];
    end
  end

  initial begin
    int acc;
    aresetn       = 1'b0;
    DAC_control   = 4'h0;
    clk_div       = 16'd10;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = 16'h0;

    repeat (5) @(negedge aclk);
    check_eq("rst_data", DACdata, ZERO);
    check_eq("rst_clk", ClockToDAC, 0);
    check_eq("rst_tready", S_AXIS_tready, 0);
    check_eq("rst_status", status, 32'h0800_0000);
    aresetn = 1'b1;
    check_eq("tready_before_edge", S_AXIS_tready, 0);
    @(posedge aclk); #1;
    check_eq("tready_after_release", S_AXIS_tready, 1);
    @(negedge aclk);
    mon_en = 1'b1;

    // ramp at clk_div = 10
    exp_div = 10;
    DAC_control = 4'h1;
    for (int i = 0; i < 100; i++) send(16'(i));
    wait_drained("ramp_drain", 2000);
    check_eq("ramp_ucnt", status[15:0], 0);
    DAC_control = 4'h0;
    repeat (3) @(negedge aclk);

    // underflow at clk_div = 4
    clk_div = 16'd4;
    exp_div = 4;
    DAC_control = 4'h1;
    for (int i = 0; i < 8; i++) send((i == 1) ? 16'hFFFF : 16'(i * 16'h0123));
    wait_drained("uf_drain1", 200);
    wait_state("uf_to_prime", 2'd1, 50);
    check_eq("uf_data", DACdata, ZERO);
    check_eq("uf_cnt", status[15:0], 1);
    check_eq("uf_state", status[25:24], 1);
    for (int i = 0; i < 8; i++) send(16'(i * 16'h0321 + 5));
    wait_drained("uf_drain2", 200);
    DAC_control = 4'h3;
    @(negedge aclk);
    DAC_control = 4'h0;
    check_eq("uf_clear", status[15:0], 0);
    repeat (3) @(negedge aclk);

    // backpressure while idle
    acc = 0;
    S_AXIS_tvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      S_AXIS_tdata = 16'hA000 + 16'(k);
      if (S_AXIS_tready) begin
        exp_q.push_back(coded(S_AXIS_tdata));
        acc++;
      end
      @(negedge aclk);
    end
    S_AXIS_tvalid = 1'b0;
    check_eq("bp_accepted", acc, 16);
    check_eq("bp_tready", S_AXIS_tready, 0);
    check_eq("bp_level", status[23:16], 16);
    check_eq("bp_full", status[26], 1);
    check_eq("bp_clk", ClockToDAC, 0);

    // divider floor and mid-run clk_div change
    clk_div = 16'd1;
    exp_div = 2;
    DAC_control = 4'h1;
    repeat (14) @(negedge aclk);
    clk_div = 16'd6;
    wait_drained("floor_drain", 200);
    DAC_control = 4'h0;
    repeat (2) @(negedge aclk);
    exp_div = 6;
    DAC_control = 4'h1;
    for (int i = 0; i < 8; i++) send(16'h0B00 + 16'(i));
    wait_drained("div6_drain", 300);

    // asynchronous reset during RUN
    for (int i = 0; i < 8; i++) send(16'h0C00 + 16'(i));
    wait_state("run_before_rst", 2'd2, 200);
    repeat (3) @(negedge aclk);
    mon_en = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b0;
    DAC_control = 4'h0;
    #1;
    check_eq("arst_data", DACdata, ZERO);
    check_eq("arst_clk", ClockToDAC, 0);
    check_eq("arst_tready", S_AXIS_tready, 0);
    check_eq("arst_status", status, 32'h0800_0000);
    exp_q.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check_eq("post_rst_level", status[23:16], 0);
    check_eq("post_rst_state", status[25:24], 0);
    check_eq("post_rst_tready", S_AXIS_tready, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
